// File: rtl/io_port_pkg.sv
// Shared definitions for the I/O port pin-side driver: default port width
// and the TX state machine encoding.
package io_port_pkg;

    localparam int unsigned IO_PORT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } io_state_t;

endpackage

// File: rtl/io_port_fifo.sv
// Small synchronous FIFO for TX bytes. Pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits match.
module io_port_fifo
    import io_port_pkg::*;
#(
    parameter int unsigned WIDTH = IO_PORT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/io_port_driver.sv
// Pin-side peer of the processor I/O port. Queues TX bytes and holds each on
// the core-input pins for HOLD_CYCLES cycles; captures core-output pins and
// reports changes over a valid/ready channel.
// Optional feature macro: IO_PORT_DRIVER_OVERRUN_EN adds a sticky rx_overrun
// flag with ovr_clear input.
module io_port_driver
    import io_port_pkg::*;
#(
    parameter int unsigned WIDTH       = IO_PORT_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] pin_dir,
    inout  logic [WIDTH-1:0] dataport,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy
`ifdef IO_PORT_DRIVER_OVERRUN_EN
    ,
    output logic             rx_overrun,
    input  logic             ovr_clear
`endif
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    io_state_t        state;
    io_state_t        state_next;
    logic [WIDTH-1:0] drive_val;
    logic [WIDTH-1:0] drive_next;
    logic [HW-1:0]    hold_cnt;
    logic [HW-1:0]    hold_next;

    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    logic [WIDTH-1:0] rx_sample;
    logic [WIDTH-1:0] sample_now;
    logic             sample_changed;

    assign tx_ready = !fifo_full;
    assign busy     = (state == DRIVE) || !fifo_empty;

    io_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Per-bit tri-state: drive only the pins the core reads as inputs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign dataport[i] = pin_dir[i] ? drive_val[i] : 1'bz;
    end

    // TX state, held byte and hold counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drive_val <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            drive_val <= drive_next;
            hold_cnt  <= hold_next;
        end
    end

    // TX sequencing: pop a byte when idle or when the current hold expires.
    always_comb begin
        state_next = state;
        drive_next = drive_val;
        hold_next  = hold_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    drive_next = fifo_head;
                    hold_next  = HOLD_INIT;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_cnt != '0) begin
                    hold_next = hold_cnt - HW'(1);
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    drive_next = fifo_head;
                    hold_next  = HOLD_INIT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sample_now     = dataport & ~pin_dir;
    assign sample_changed = (sample_now != rx_sample);

    // Capture channel: latest changed sample wins; a change beats a consume.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sample <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_sample <= sample_now;
            if (sample_changed) begin
                rx_data  <= sample_now;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef IO_PORT_DRIVER_OVERRUN_EN
    // Sticky overrun: set when a pending capture is overwritten; set beats clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
        end else if (sample_changed && rx_valid && !rx_ready) begin
            rx_overrun <= 1'b1;
        end else if (ovr_clear) begin
            rx_overrun <= 1'b0;
        end
    end
`endif

endmodule
